serv_dbus_sram: RTL and testbench

Wishbone-classic data-bus slave that sits directly downstream of the SERV memory interface. It accepts the core's dbus requests (address, write data, byte selects from the memory interface, write enable, cycle) and turns each one into a single access to a single-port synchronous SRAM. Read data returns with a one-cycle acknowledge after a configurable number of wait states. Addresses outside the SRAM window complete harmlessly and flag an out-of-range pulse.

---
 rtl/serv_dbus_sram.sv | 128 ++++++++++++
 tb/tb_serv_dbus_sram.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serv_dbus_sram.sv
// Wishbone-classic data-bus slave for the SERV core that performs one single-port SRAM access per request.
// Wait states are configurable; addresses beyond the SRAM window complete without touching memory.
module serv_dbus_sram #(
  parameter int unsigned AW   = 10,
  parameter int unsigned WAIT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_oob,
  output logic          o_mem_en,
  output logic [3:0]    o_mem_wen,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] WAIT_LD = (WAIT == 0) ? '0 : (CW'(WAIT) - CW'(1));

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   adr_q;
  logic [31:0]     dat_q;
  logic [3:0]      sel_q;
  logic            we_q;
  logic            oob_q;
  logic            rd_pend_q;
  logic [31:0]     cap_q;
  logic [31:0]     rdt_q;
  logic [31:0]     rdt_c;
  logic            unused_adr_lsb;

  // Byte offset is carried by the lane selects.
  assign unused_adr_lsb = ^i_wb_adr[1:0];

  // State, request capture and read-data registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      oob_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      cap_q     <= '0;
      rdt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (state_q == S_IDLE && i_wb_cyc) begin
        adr_q <= i_wb_adr[AW+1:2];
        dat_q <= i_wb_dat;
        sel_q <= i_wb_sel;
        we_q  <= i_wb_we;
        oob_q <= |i_wb_adr[31:AW+2];
      end
      // SRAM read data is valid only in the cycle right after ACCESS.
      rd_pend_q <= (state_q == S_ACCESS) && !we_q && !oob_q;
      if (rd_pend_q)
        cap_q <= i_mem_rdata;
      if (state_q == S_ACK && !we_q)
        rdt_q <= rdt_c;
    end
  end

  // Next state and state-decoded strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_mem_en  = 1'b0;
    o_mem_wen = 4'b0000;
    o_wb_ack  = 1'b0;
    o_oob     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_wb_cyc)
          state_d = S_ACCESS;
      end
      S_ACCESS: begin
        o_mem_en  = !oob_q;
        o_mem_wen = sel_q & {4{we_q & !oob_q}};
        cnt_d     = WAIT_LD;
        state_d   = (WAIT > 0) ? S_WAIT : S_ACK;
      end
      S_WAIT: begin
        if (cnt_q == '0)
          state_d = S_ACK;
        else
          cnt_d = cnt_q - CW'(1);
      end
      S_ACK: begin
        o_wb_ack = 1'b1;
        o_oob    = oob_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With no wait states the ack cycle is the SRAM data cycle, so forward it directly.
  always_comb begin
    rdt_c = rdt_q;
    if (state_q == S_ACK && !we_q) begin
      if (oob_q)
        rdt_c = '0;
      else if (rd_pend_q)
        rdt_c = i_mem_rdata;
      else
        rdt_c = cap_q;
    end
  end

  assign o_wb_rdt    = rdt_c;
  assign o_mem_addr  = adr_q;
  assign o_mem_wdata = dat_q;

endmodule

// File: tb/tb_serv_dbus_sram.sv
// Bench for serv_dbus_sram: three instances (WAIT=0,3,4) each with a behavioural SRAM,
// directed transfers checked against a byte-lane reference memory through a scoreboard queue.
module tb_serv_dbus_sram;

  localparam int unsigned AW    = 10;
  localparam int unsigned N     = 3;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic [31:0] rdt;
    logic        oob;
    logic        rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [N];
  logic          cyc   [N];
  logic [31:0]   adr, dat;
  logic [3:0]    sel;
  logic          we;
  logic [31:0]   rdt   [N];
  logic          ack   [N];
  logic          oob   [N];
  logic          en    [N];
  logic [3:0]    wen   [N];
  logic [AW-1:0] maddr [N];
  logic [31:0]   wdata [N];
  logic [31:0]   rdata [N];

  logic [31:0] sram     [N][DEPTH];
  logic [31:0] ref_mem  [N][DEPTH];
  logic [31:0] last_rdt [N];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  serv_dbus_sram #(.AW(AW), .WAIT(0)) u_w0 (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc[0]), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]), .o_oob(oob[0]),
    .o_mem_en(en[0]), .o_mem_wen(wen[0]), .o_mem_addr(maddr[0]), .o_mem_wdata(wdata[0]),
    .i_mem_rdata(rdata[0]));

  serv_dbus_sram #(.AW(AW), .WAIT(3)) u_w3 (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc[1]), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]), .o_oob(oob[1]),
    .o_mem_en(en[1]), .o_mem_wen(wen[1]), .o_mem_addr(maddr[1]), .o_mem_wdata(wdata[1]),
    .i_mem_rdata(rdata[1]));

  serv_dbus_sram #(.AW(AW), .WAIT(4)) u_w4 (
    .i_clk(clk), .i_rst_n(rst_n[2]), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc[2]), .o_wb_rdt(rdt[2]), .o_wb_ack(ack[2]), .o_oob(oob[2]),
    .o_mem_en(en[2]), .o_mem_wen(wen[2]), .o_mem_addr(maddr[2]), .o_mem_wdata(wdata[2]),
    .i_mem_rdata(rdata[2]));

  // Single-port SRAMs without reset; read data appears the cycle after an enabled access.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        rdata[i] <= sram[i][maddr[i]];
        for (int b = 0; b < 4; b++)
          if (wen[i][b]) sram[i][maddr[i]][8*b +: 8] <= wdata[i][8*b +: 8];
      end
    end
  end

  function automatic int wait_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one transfer on instance i (called just after a rising edge) and check its completion.
  task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag);
    exp_t          e;
    int            n, en_n;
    logic          got_ack, oob_ack;
    logic [31:0]   rdt_ack;
    logic [3:0]    wen1;
    logic [AW-1:0] addr1;
    logic          is_oob;
    is_oob = |a[31:AW+2];
    e.oob  = is_oob;
    e.rd   = !w;
    if (w) begin
      e.rdt = last_rdt[i];
      if (!is_oob)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[i][a[AW+1:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.rdt = is_oob ? 32'h0 : ref_mem[i][a[AW+1:2]];
      last_rdt[i] = e.rdt;
    end
    sb.push_back(e);

    adr = a; dat = d; sel = s; we = w; cyc[i] = 1'b1;
    n = 0; en_n = 0; got_ack = 1'b0; oob_ack = 1'b0; rdt_ack = '0; wen1 = '0; addr1 = '0;
    while (!got_ack && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (en[i]) en_n++;
      if (n == 1) begin
        wen1  = wen[i];
        addr1 = maddr[i];
      end
      if (ack[i]) begin
        got_ack = 1'b1;
        rdt_ack = rdt[i];
        oob_ack = oob[i];
      end
    end
    @(posedge clk);
    #1 cyc[i] = 1'b0;

    e = sb.pop_front();
    chk({tag, " ack"}, 32'(got_ack), 32'd1);
    chk({tag, " latency"}, 32'(n), 32'(2 + wait_of(i)));
    chk({tag, " oob"}, 32'(oob_ack), 32'(e.oob));
    chk({tag, " rdt"}, rdt_ack, e.rdt);
    chk({tag, " en cycles"}, 32'(en_n), e.oob ? 32'd0 : 32'd1);
    chk({tag, " wen"}, 32'(wen1), (w && !e.oob) ? 32'(s) : 32'd0);
    chk({tag, " mem addr"}, 32'(addr1), 32'(a[AW+1:2]));
  endtask

  // Start a full-word write on instance i and pull reset after k rising edges.
  task automatic reset_during(input int i, input logic [31:0] a, input logic [31:0] d,
                              input int k, input string tag);
    int acks, ens;
    adr = a; dat = d; sel = 4'hF; we = 1'b1; cyc[i] = 1'b1;
    repeat (k) @(posedge clk);
    #1 rst_n[i] = 1'b0;
    cyc[i] = 1'b0;
    ref_mem[i][a[AW+1:2]] = d;
    last_rdt[i] = 32'h0;
    acks = 0; ens = 0;
    @(posedge clk);
    repeat (8) begin
      @(negedge clk);
      if (ack[i]) acks++;
      if (en[i]) ens++;
    end
    chk({tag, " no ack"}, 32'(acks), 32'd0);
    chk({tag, " en idle"}, 32'(ens), 32'd0);
    chk({tag, " rdt reset"}, rdt[i], 32'h0);
    @(posedge clk);
    #1 rst_n[i] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      cyc[i] = 1'b0;
      last_rdt[i] = 32'h0;
    end
    adr = 32'h10; dat = 32'hDEADBEEF; sel = 4'hF; we = 1'b1;
    cyc[0] = 1'b1;

    // Reset held with a pending request: nothing may happen.
    repeat (3) begin
      @(negedge clk);
      chk("reset ack", 32'(ack[0]), 32'd0);
      chk("reset en", 32'(en[0]), 32'd0);
      chk("reset rdt", rdt[0], 32'h0);
    end
    @(posedge clk);
    #1 for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

    xfer(0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, "w0 wr10");
    xfer(0, 1'b0, 32'h0000_0010, 32'h0,        4'hF, "w0 rd10");
    chk("w0 rd10 value", last_rdt[0], 32'hDEADBEEF);

    xfer(0, 1'b1, 32'h0000_0020, 32'h11223344, 4'hF, "w0 wr20");
    xfer(0, 1'b1, 32'h0000_0020, 32'hAA000000, 4'h8, "w0 wr20 lane3");
    xfer(0, 1'b0, 32'h0000_0020, 32'h0,        4'hF, "w0 rd20");
    chk("w0 rd20 merged", last_rdt[0], 32'hAA223344);
    xfer(0, 1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, "w0 wr20 sel0");
    xfer(0, 1'b0, 32'h0000_0020, 32'h0,        4'hF, "w0 rd20 after sel0");

    xfer(0, 1'b1, 32'h0000_0000, 32'h5A5A5A5A, 4'hF, "w0 wr0");
    xfer(0, 1'b1, 32'h0000_1000, 32'hFFFFFFFF, 4'hF, "w0 oob wr");
    xfer(0, 1'b0, 32'h0000_1000, 32'h0,        4'hF, "w0 oob rd");
    xfer(0, 1'b0, 32'h0000_0000, 32'h0,        4'hF, "w0 rd0 intact");
    chk("w0 rd0 value", last_rdt[0], 32'h5A5A5A5A);

    xfer(1, 1'b1, 32'h0000_0030, 32'h0BADF00D, 4'hF, "w3 wr30");
    xfer(1, 1'b0, 32'h0000_0030, 32'h0,        4'hF, "w3 rd30");
    xfer(1, 1'b0, 32'h8000_0000, 32'h0,        4'hF, "w3 oob rd");
    xfer(1, 1'b1, 32'h0000_0034, 32'h00C0FFEE, 4'h3, "w3 wr34 lo");

    xfer(2, 1'b1, 32'h0000_0040, 32'h600DCAFE, 4'hF, "w4 wr40");
    reset_during(2, 32'h0000_0044, 32'hCAFEF00D, 2, "w4 rst in wait");
    xfer(2, 1'b0, 32'h0000_0044, 32'h0,        4'hF, "w4 rd44");
    xfer(2, 1'b0, 32'h0000_0040, 32'h0,        4'hF, "w4 rd40");
    reset_during(2, 32'h0000_0048, 32'h13579BDF, 1, "w4 rst in access");
    xfer(2, 1'b0, 32'h0000_0048, 32'h0,        4'hF, "w4 rd48");
    chk("w4 rd48 value", last_rdt[2], 32'h13579BDF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
